// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : FSM state and funct3 encodings shared by the load/store unit
// rev 1.0
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/lsu_fmt.sv
`default_nettype none
// ============================================================================
// lsu_fmt : byte enables, store lane replication, load extraction and checks
// rev 1.0
// ============================================================================
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3_i,
  input  logic [1:0]  req_off_i,
  input  logic        req_store_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o,
  output logic        misaligned_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] w_lane;

  always_comb begin
    illegal_o = 1'b0;
    case (req_funct3_i)
      F3_B, F3_H, F3_W: illegal_o = 1'b0;
      F3_BU, F3_HU:     illegal_o = req_store_i;
      default:          illegal_o = 1'b1;
    endcase

    misaligned_o = 1'b0;
    be_o         = 4'b1111;
    wdata_o      = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned_o = req_off_i[0];
        be_o         = 4'b0011 << req_off_i;
        wdata_o      = {2{req_wdata_i[15:0]}};
      end
      default: misaligned_o = (req_off_i != 2'b00);
    endcase
  end

  // Word loads are always aligned, so the shifted lane equals the raw word.
  assign w_lane = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = w_lane;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_BU:   ld_data_o = {24'd0, w_lane[7:0]};
      F3_H:    ld_data_o = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_HU:   ld_data_o = {16'd0, w_lane[15:0]};
      default: ld_data_o = w_lane;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : single-outstanding Memory-stage load/store bus master
// rev 1.0
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        ErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int            CNT_W    = $clog2(MEM_LAT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT_MAX - 1);

  lsu_state_e        state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_access;

  lsu_fmt u_fmt (
    .req_funct3_i (funct3M),
    .req_off_i    (ALUResultM[1:0]),
    .req_store_i  (MemWriteM),
    .req_wdata_i  (WriteDataM),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .illegal_o    (w_illegal),
    .misaligned_o (w_misaligned),
    .ld_funct3_i  (f3_q),
    .ld_off_i     (off_q),
    .ld_rdata_i   (mem_rdata),
    .ld_data_o    (w_ld_data)
  );

  assign w_access = MemReadM | MemWriteM;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    StallM  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_access) begin
          if (w_illegal || w_misaligned) begin
            err_d = 1'b1;
          end else begin
            StallM  = 1'b1;
            req_d   = 1'b1;
            we_d    = MemWriteM;
            addr_d  = {ALUResultM[31:2], 2'b00};
            be_d    = w_be;
            wdata_d = w_wdata;
            f3_d    = funct3M;
            off_d   = ALUResultM[1:0];
            cnt_d   = '0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        StallM = 1'b1;
        if (mem_ready) begin
          if (!we_q) rdata_d = w_ld_data;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ReadDataM = rdata_q;
  assign ErrM      = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : vector table, corner sequences and randomized model check
// rev 1.0
// ============================================================================
module tb_load_store_unit;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, ErrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LAT_MAX(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .ErrM       (ErrM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd;

  // delay: cycle of ACCESS (1-based) in which mem_ready rises; 0 = never
  typedef struct {
    logic rd; logic wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
    int delay; logic [31:0] rdata;
    int e_stall; int e_err; int e_req; logic [3:0] e_be; logic [31:0] e_wdata; logic [31:0] e_rdm;
  } vec_t;

  typedef struct {
    int stalls; int errs; int reqs;
    logic [3:0] be; logic [31:0] wdata; logic [31:0] addr; logic we;
    logic [31:0] rdm; bit done;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0;
    ALUResultM = 32'd0; WriteDataM = 32'd0;
  endtask

  // Presents one instruction until the pipeline is released, acting as the bus slave.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input int delay,
                            input logic [31:0] rdata, output obs_t o);
    int  req_cnt = 0;
    bit  leaving = 1'b0;
    o = '{default: 0};
    for (int k = 0; k < LAT + 10 && !leaving; k++) begin
      MemReadM = rd; MemWriteM = wr; funct3M = f3;
      ALUResultM = addr; WriteDataM = wd; mem_rdata = rdata;
      if (mem_req) begin
        req_cnt++;
        mem_ready = (req_cnt == delay);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      o.stalls += int'(StallM);
      o.errs   += int'(ErrM);
      if (mem_req) begin
        o.reqs++;
        o.be = mem_be; o.wdata = mem_wdata; o.addr = mem_addr; o.we = mem_we;
      end
      if (!StallM) begin
        leaving = 1'b1;
        o.done  = 1'b1;
        o.rdm   = ReadDataM;
      end
      @(posedge clk); #1;
    end
    drive_idle();
    repeat (2) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      o.errs += int'(ErrM);
      o.reqs += int'(mem_req);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic check_obs(input string tag, input obs_t o, input logic wr, input logic [31:0] addr,
                           input int e_stall, input int e_err, input int e_req,
                           input logic [3:0] e_be, input logic [31:0] e_wdata, input logic [31:0] e_rdm);
    chk({tag, " completed"}, 32'(o.done), 32'd1);
    chk({tag, " stall cycles"}, o.stalls, e_stall);
    chk({tag, " err pulses"}, o.errs, e_err);
    chk({tag, " req cycles"}, o.reqs, e_req);
    chk({tag, " ReadDataM"}, o.rdm, e_rdm);
    if (e_req > 0) begin
      chk({tag, " mem_be"}, 32'(o.be), 32'(e_be));
      chk({tag, " mem_wdata"}, o.wdata, e_wdata);
      chk({tag, " mem_addr"}, o.addr, addr & 32'hFFFF_FFFC);
      chk({tag, " mem_we"}, 32'(o.we), 32'(wr));
    end
  endtask

  // Reference: derives the observable outcome of one instruction from the access rules.
  task automatic model(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int delay, input logic [31:0] rdata,
                       output int e_stall, output int e_err, output int e_req,
                       output logic [3:0] e_be, output logic [31:0] e_wdata, output logic [31:0] e_rdm);
    int size, off;
    bit legal, valid, tmo;
    logic [31:0] lane, v;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    off   = int'(addr % 4);
    legal = (size != 0) && !(wr && f3 >= 3'd4);
    valid = (rd || wr) && legal && ((off % size) == 0);
    tmo   = valid && (delay == 0 || delay > LAT);
    e_stall = valid ? (tmo ? LAT + 1 : delay + 1) : 0;
    e_err   = (((rd || wr) && !valid) || tmo) ? 1 : 0;
    e_req   = valid ? (tmo ? LAT : delay) : 0;
    e_be    = (size == 1) ? 4'(1 << off) : (size == 2) ? 4'(3 << off) : 4'hF;
    e_wdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
              (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    if (valid && !wr && !tmo) begin
      lane = rdata >> (8 * off);
      if (size == 1) begin
        v = lane & 32'hFF;
        if (f3 == 3'd0 && v > 32'd127) v = v + 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = lane & 32'hFFFF;
        if (f3 == 3'd1 && v > 32'd32767) v = v + 32'hFFFF_0000;
      end else begin
        v = rdata;
      end
      model_rd = v;
    end
    e_rdm = model_rd;
  endtask

  vec_t vt[16];
  obs_t o;

  initial begin
    vt[0]  = '{1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1, 32'h0,        2, 0, 1, 4'hF, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 3'd0, 32'h103, 32'h0,        1, 32'h80FF7F01, 2, 0, 1, 4'h8, 32'h0,        32'hFFFFFF80};
    vt[2]  = '{1'b1, 1'b0, 3'd4, 32'h103, 32'h0,        1, 32'h80FF7F01, 2, 0, 1, 4'h8, 32'h0,        32'h00000080};
    vt[3]  = '{1'b1, 1'b0, 3'd1, 32'h102, 32'h0,        1, 32'h80011234, 2, 0, 1, 4'hC, 32'h0,        32'hFFFF8001};
    vt[4]  = '{1'b1, 1'b0, 3'd2, 32'h101, 32'h0,        1, 32'h12345678, 0, 1, 0, 4'h0, 32'h0,        32'hFFFF8001};
    vt[5]  = '{1'b0, 1'b1, 3'd0, 32'h201, 32'h000000AB, 5, 32'h0,        6, 0, 5, 4'h2, 32'hABABABAB, 32'hFFFF8001};
    vt[6]  = '{1'b1, 1'b0, 3'd5, 32'h100, 32'h0,        2, 32'h1234F00D, 3, 0, 2, 4'h3, 32'h0,        32'h0000F00D};
    vt[7]  = '{1'b0, 1'b1, 3'd1, 32'h102, 32'hFFFFC0DE, 1, 32'h0,        2, 0, 1, 4'hC, 32'hC0DEC0DE, 32'h0000F00D};
    vt[8]  = '{1'b0, 1'b1, 3'd4, 32'h100, 32'h1,        1, 32'h0,        0, 1, 0, 4'h0, 32'h0,        32'h0000F00D};
    vt[9]  = '{1'b1, 1'b0, 3'd3, 32'h100, 32'h0,        1, 32'h0,        0, 1, 0, 4'h0, 32'h0,        32'h0000F00D};
    vt[10] = '{1'b1, 1'b0, 3'd2, 32'h104, 32'h0,        1, 32'hCAFEF00D, 2, 0, 1, 4'hF, 32'h0,        32'hCAFEF00D};
    vt[11] = '{1'b1, 1'b0, 3'd2, 32'h108, 32'h0,        0, 32'h99999999, LAT+1, 1, LAT, 4'hF, 32'h0,  32'hCAFEF00D};
    vt[12] = '{1'b1, 1'b1, 3'd2, 32'h10C, 32'h11223344, 1, 32'h55555555, 2, 0, 1, 4'hF, 32'h11223344, 32'hCAFEF00D};
    vt[13] = '{1'b1, 1'b0, 3'd1, 32'h101, 32'h0,        1, 32'h0,        0, 1, 0, 4'h0, 32'h0,        32'hCAFEF00D};
    vt[14] = '{1'b1, 1'b0, 3'd0, 32'h100, 32'h0,        3, 32'h0000007F, 4, 0, 3, 4'h1, 32'h0,        32'h0000007F};
    vt[15] = '{1'b0, 1'b0, 3'd2, 32'h101, 32'h0,        1, 32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h0000007F};

    rst = 1'b0;
    drive_idle();
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ReadDataM", ReadDataM, 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset ErrM", 32'(ErrM), 32'd0);
    chk("reset StallM", 32'(StallM), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_access(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wd, vt[i].delay, vt[i].rdata, o);
      check_obs($sformatf("vec%0d", i), o, vt[i].wr, vt[i].addr, vt[i].e_stall, vt[i].e_err,
                vt[i].e_req, vt[i].e_be, vt[i].e_wdata, vt[i].e_rdm);
    end

    // Reset in the middle of an outstanding load.
    MemReadM = 1'b1; funct3M = 3'd2; ALUResultM = 32'h200; mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort mem_req up", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    chk("abort mem_req", 32'(mem_req), 32'd0);
    chk("abort ReadDataM", ReadDataM, 32'd0);
    chk("abort mem_be", 32'(mem_be), 32'd0);
    chk("abort mem_addr", mem_addr, 32'd0);
    chk("abort StallM", 32'(StallM), 32'd0);
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-abort idle%0d mem_req", k), 32'(mem_req), 32'd0);
      chk($sformatf("post-abort idle%0d ReadDataM", k), ReadDataM, 32'd0);
    end
    mem_ready = 1'b0;
    model_rd = 32'd0;

    for (int n = 0; n < 150; n++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rdata;
      int          dly, e_stall, e_err, e_req;
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_rdm;
      rd    = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 3) == 0);
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom & 32'h0000_0FFF;
      wd    = $urandom;
      rdata = $urandom;
      dly   = $urandom_range(1, LAT + 2);
      model(rd, wr, f3, addr, wd, dly, rdata, e_stall, e_err, e_req, e_be, e_wdata, e_rdm);
      run_access(rd, wr, f3, addr, wd, dly, rdata, o);
      check_obs($sformatf("rand%0d", n), o, wr, addr, e_stall, e_err, e_req, e_be, e_wdata, e_rdm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
